// File: rtl/shooter_pkg.sv
// Shared screen geometry and position type for the shooter's bullet and enemy logic.
package shooter_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int POS_W    = 10;

  typedef logic [POS_W-1:0] pos_t;

  // Spawn x sits to the right of the sprite and must not land past the last column.
  function automatic pos_t spawn_x_sat(pos_t px, int unsigned ofs);
    logic [POS_W:0] sum;
    sum = {1'b0, px} + (POS_W+1)'(ofs);
    if (sum > (POS_W+1)'(SCREEN_W - 1)) return pos_t'(SCREEN_W - 1);
    return sum[POS_W-1:0];
  endfunction

  function automatic pos_t spawn_y_clamp(pos_t py, int unsigned ofs);
    if (py < pos_t'(ofs)) return '0;
    return py - pos_t'(ofs);
  endfunction

endpackage

// File: rtl/bullet_pool_scheduler_if.sv
// Fire request, hit feedback and bullet pool state exchanged with the player and collision logic.
interface bullet_pool_scheduler_if #(parameter int BULLET_COUNT = 8);
  import shooter_pkg::*;

  logic                    fire_req;
  pos_t                    player_x;
  pos_t                    player_y;
  logic [BULLET_COUNT-1:0] bullet_hit;
  pos_t                    bullet_x [BULLET_COUNT];
  pos_t                    bullet_y [BULLET_COUNT];
  logic [BULLET_COUNT-1:0] bullet_active;
  logic                    fire_ack;
  logic                    fire_blocked;
  logic [15:0]             shots_fired;

  modport master (
    output fire_req, player_x, player_y, bullet_hit,
    input  bullet_x, bullet_y, bullet_active, fire_ack, fire_blocked, shots_fired
  );

  modport slave (
    input  fire_req, player_x, player_y, bullet_hit,
    output bullet_x, bullet_y, bullet_active, fire_ack, fire_blocked, shots_fired
  );
endinterface

// File: rtl/bullet_pool_scheduler_free_slot_finder.sv
// Lowest-index free slot encoder over the registered active vector.
module free_slot_finder #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     busy,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan downward so the last hit, i.e. the lowest index, wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bullet_pool_scheduler.sv
// Player bullet pool: spawns on fire with cooldown, moves bullets up each frame, retires on hit or off-top.
module bullet_pool_scheduler
  import shooter_pkg::*;
#(
  parameter int BULLET_COUNT  = 8,
  parameter int FIRE_COOLDOWN = 12,
  parameter int BULLET_SPEED  = 4,
  parameter int SPAWN_X_OFS   = 14,
  parameter int SPAWN_Y_OFS   = 8
) (
  input  logic                    clk25,
  input  logic                    reset_n,
  input  logic                    frame_tick,
  input  logic                    run,
  input  logic                    clear_all,
  bullet_pool_scheduler_if.slave  bus
);

  localparam int IDX_W = (BULLET_COUNT > 1) ? $clog2(BULLET_COUNT) : 1;

  logic [BULLET_COUNT-1:0] active_vec;
  logic                    free_found;
  logic [IDX_W-1:0]        free_idx;
  logic [7:0]              cooldown_q;
  logic [15:0]             shots_q;
  logic                    ack_q;
  logic                    blocked_q;
  logic                    tick_en;
  logic                    fire_ready;
  logic                    spawn_go;
  logic                    pool_full;
  pos_t                    spawn_x;
  pos_t                    spawn_y;

  free_slot_finder #(.N(BULLET_COUNT), .IDX_W(IDX_W)) u_finder (
    .busy  (active_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  assign tick_en    = frame_tick & run & ~clear_all;
  assign fire_ready = tick_en & bus.fire_req & (cooldown_q == 8'd0);
  assign spawn_go   = fire_ready & free_found;
  assign pool_full  = fire_ready & ~free_found;
  assign spawn_x    = spawn_x_sat(bus.player_x, SPAWN_X_OFS);
  assign spawn_y    = spawn_y_clamp(bus.player_y, SPAWN_Y_OFS);

  // A slot freed this cycle is still marked active in active_vec, so it cannot be reused until the next tick.
  for (genvar j = 0; j < BULLET_COUNT; j++) begin : g_slot
    logic act_q;
    pos_t x_q;
    pos_t y_q;
    logic hit_j;
    logic take_j;

    assign hit_j  = bus.bullet_hit[j] & act_q;
    assign take_j = spawn_go & (free_idx == IDX_W'(j));

    always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
        act_q <= 1'b0;
        x_q   <= '0;
        y_q   <= '0;
      end else if (clear_all) begin
        act_q <= 1'b0;
      end else if (hit_j) begin
        act_q <= 1'b0;
      end else if (tick_en) begin
        if (act_q) begin
          if (y_q < pos_t'(BULLET_SPEED)) act_q <= 1'b0;
          else                            y_q   <= y_q - pos_t'(BULLET_SPEED);
        end else if (take_j) begin
          act_q <= 1'b1;
          x_q   <= spawn_x;
          y_q   <= spawn_y;
        end
      end
    end

    assign active_vec[j]        = act_q;
    assign bus.bullet_active[j] = act_q;
    assign bus.bullet_x[j]      = x_q;
    assign bus.bullet_y[j]      = y_q;
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      cooldown_q <= '0;
      shots_q    <= '0;
      ack_q      <= 1'b0;
      blocked_q  <= 1'b0;
    end else begin
      ack_q     <= spawn_go;
      blocked_q <= pool_full;
      if (clear_all) begin
        cooldown_q <= '0;
      end else if (tick_en) begin
        if (spawn_go)                cooldown_q <= 8'(FIRE_COOLDOWN);
        else if (cooldown_q != 8'd0) cooldown_q <= cooldown_q - 8'd1;
      end
      if (spawn_go) shots_q <= shots_q + 16'd1;
    end
  end

  assign bus.fire_ack     = ack_q;
  assign bus.fire_blocked = blocked_q;
  assign bus.shots_fired  = shots_q;

endmodule

// File: doc/bullet_pool_scheduler.md
Name: bullet_pool_scheduler

Overview:
- Owns the player's bullet pool and feeds position/active arrays to the enemy collision controller.
- Per frame it allocates a free slot on a fire request, enforces a fire cooldown, advances bullets upward and retires bullets that leave the screen.
- Consumes the collision controller's `bullet_hit` pulses to free slots.

Parameters:
- BULLET_COUNT, 8, number of bullet slots (1..16).
- FIRE_COOLDOWN, 12, frames between accepted shots (1..255).
- BULLET_SPEED, 4, pixels moved up per frame_tick (1..15).
- SPAWN_X_OFS, 14, x offset added to player_x at spawn.
- SPAWN_Y_OFS, 8, y offset subtracted from player_y at spawn.

Ports:
- clk25  in  1  25 MHz pixel clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- run  in  1  game running; when low, ticks are ignored.
- clear_all  in  1  synchronous pulse that deactivates every slot and zeroes the cooldown.
- fire_req  in  1  level fire button, already debounced.
- player_x  in  10  player sprite left x.
- player_y  in  10  player sprite top y.
- bullet_hit  in  1 x [0:BULLET_COUNT-1]  hit pulses from the collision controller.
- bullet_x  out  10 x [0:BULLET_COUNT-1]  slot x position.
- bullet_y  out  10 x [0:BULLET_COUNT-1]  slot y position.
- bullet_active  out  1 x [0:BULLET_COUNT-1]  slot in flight.
- fire_ack  out  1  one-cycle pulse when a shot is spawned.
- fire_blocked  out  1  one-cycle pulse when fire_req is refused because the pool is full.
- shots_fired  out  16  count of spawned shots; wraps at 0xFFFF->0.

Behaviour:
- Reset (reset_n=0, async): all bullet_x/y=0, bullet_active=0, cooldown=0, fire_ack=0, fire_blocked=0, shots_fired=0.
- All outputs are registered. fire_ack and fire_blocked default to 0 every cycle.
- Priority per cycle: clear_all > bullet_hit > frame_tick processing.
- clear_all=1: all active=0, cooldown=0. shots_fired is kept. A coincident frame_tick is ignored.
- bullet_hit[j]=1 while active[j]: active[j]=0 next cycle. Position holds. No move or spawn for slot j that cycle.
- bullet_hit[j] on an inactive slot: ignored.
- frame_tick processing runs only when frame_tick=1 and run=1. All of the following happen in the same cycle:
  - Move: each active slot j without a hit: if y < BULLET_SPEED then active[j]=0 (off top), else y -= BULLET_SPEED. No underflow is ever written.
  - Cooldown: if cooldown > 0, cooldown decrements; it saturates at 0.
  - Spawn: the condition is fire_req=1, cooldown==0 (value before this tick), and at least one slot has registered active=0.
    - Slot choice: the lowest-index free slot, taken from the registered active vector.
    - A slot freed this cycle (by hit or off-screen) is NOT eligible until the next tick.
    - Spawned slot: x = player_x + SPAWN_X_OFS, saturated at 639. y = player_y - SPAWN_Y_OFS, or 0 if player_y < SPAWN_Y_OFS. active=1.
    - A spawned bullet does not move on its spawn tick.
    - cooldown = FIRE_COOLDOWN, fire_ack=1, shots_fired += 1.
  - Pool full: fire_req=1, cooldown==0, no free slot → fire_blocked=1. Cooldown is not reloaded. No state change.
  - fire_req=1 with cooldown > 0: silently ignored.
- Timing: a shot spawns at most once per FIRE_COOLDOWN+1 ticks with fire_req held.
- frame_tick with run=0: no move, spawn or cooldown change. Hits are still processed.
- reset_n asserted mid-frame: immediate return to reset values. Operation resumes on the first tick after release.

Decomposition:
- Package shooter_pkg:
  - constants SCREEN_W=640, SCREEN_H=480, POS_W=10.
  - typedef pos_t (logic [9:0]).
  - shared with the enemy collision controller.
- Sub-module free_slot_finder: combinational lowest-index-zero priority encoder over BULLET_COUNT bits. Outputs `found` and `idx[$clog2(BULLET_COUNT)-1:0]`.
- Per-slot move/retire logic is a generate loop in the top module.

Test Plan:
- Reset, then fire_req=1, player=(300,400), one tick → slot0 active, x=314, y=392, fire_ack=1, shots_fired=1. Next tick: y=388, no new spawn.
- Hold fire_req for 40 ticks, FIRE_COOLDOWN=12 → spawns on ticks 0, 13, 26, 39 into slots 0..3. Ack spacing is 13 ticks.
- FIRE_COOLDOWN=1, fire_req held for 20 ticks with bullets in flight → all 8 slots fill. Each further eligible tick gives fire_blocked=1 with no slot changes. Hitting slot3 frees it; the next eligible tick fills slot3.
- Slot0 at y=5, BULLET_SPEED=4 → after tick y=1. Next tick → active=0.
- bullet_hit[2] in the same cycle as a frame_tick with all other slots full and fire_req=1 → slot2 cleared, no spawn that tick (fire_blocked=1). Spawn into slot2 on the following eligible tick.
- clear_all coincident with a tick and fire_req → all inactive, cooldown=0, no fire_ack. Async reset mid-flight → all outputs 0 immediately.
